// File: rtl/mdu_iterative_if.sv
// Bus between the execute stage and the iterative multiply/divide unit.
//
// Handshake: start is a request qualified by !busy. A start seen while busy
// is low is accepted on that edge, and op/a/b are sampled with it. A start
// seen while busy is high is dropped, never queued. done pulses for one
// cycle when HI/LO hold the new result; div0 is valid alongside done and
// holds until the next accepted start. hi_we/lo_we take effect only while
// busy is low, including on the accepting edge itself.
//
// state mirrors the unit's FSM (0=IDLE, 1=RUN, 2=FIX) for observation.
interface mdu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       state;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div0, hi, lo, state
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div0, hi, lo, state
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//
// One radix-2 step per cycle: shift/add for multiply, restoring subtract for
// divide. Signed operations work on magnitudes and apply the result signs in
// a final FIX cycle, so the step datapath is purely unsigned.
//
// op: 00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU.
// Multiply: {hi,lo} = full product. Divide: lo = quotient (toward zero),
// hi = remainder (sign of dividend). Divide by zero: hi=a, lo=all ones,
// div0=1.
//
// Optional build macro MDU_EARLY_OUT_EN: a multiply leaves RUN as soon as
// the remaining multiplier bits are all zero. Without it every non-div0
// operation takes WIDTH+1 edges from accept to done.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mdu_iterative_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div_q;   // operation is a divide
  logic               dz_q;       // divide with zero divisor
  logic               neg_q;      // product / quotient must be negated
  logic               negr_q;     // remainder must be negated
  logic [WIDTH-1:0]   a_q;        // raw dividend, returned in HI on div0

  // Multiply: acc accumulates the product, mcand is shifted left each step,
  // mplier is consumed from its LSB.
  // Divide: acc[WIDTH:0] holds the partial remainder, mplier starts as the
  // dividend magnitude and fills with quotient bits from the right, dvs is
  // the divisor magnitude.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   dvs;

  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               div0_q;

  // Operand conditioning at accept time
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Step datapath
  logic [2*WIDTH-1:0] mul_acc_nx;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     dvs_ext;
  logic               div_ge;
  logic [WIDTH:0]     rem_nx;

  // Sign fixup
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Signed ops (op[0]==0) take the magnitude of negative operands
  always_comb begin
    a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  // One shift/add or restoring-subtract step on the current registers
  always_comb begin
    mul_acc_nx = mplier[0] ? (acc + mcand) : acc;
    rem_sh     = {acc[WIDTH-1:0], mplier[WIDTH-1]};
    dvs_ext    = {1'b0, dvs};
    div_ge     = (rem_sh >= dvs_ext);
    rem_nx     = div_ge ? (rem_sh - dvs_ext) : rem_sh;
  end

  // Apply recorded result signs to the unsigned results
  always_comb begin
    prod_fix = neg_q  ? -acc : acc;
    quot_fix = neg_q  ? -mplier : mplier;
    rem_fix  = negr_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  // Control FSM, iteration registers and architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      a_q      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      dvs      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            is_div_q <= bus.op[1];
            dz_q     <= bus.op[1] && (bus.b == '0);
            neg_q    <= a_neg ^ b_neg;
            negr_q   <= a_neg;
            a_q      <= bus.a;
            div0_q   <= 1'b0;
            acc      <= '0;
            cnt      <= CW'(WIDTH - 1);
            if (bus.op[1]) begin
              mcand  <= '0;
              mplier <= a_mag;
              dvs    <= b_mag;
              state  <= (bus.b == '0) ? S_FIX : S_RUN;
            end else begin
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              dvs    <= '0;
              state  <= S_RUN;
            end
          end
        end

        S_RUN: begin
          cnt <= cnt - CW'(1);
          if (is_div_q) begin
            acc    <= {{(WIDTH-1){1'b0}}, rem_nx};
            mplier <= {mplier[WIDTH-2:0], div_ge};
          end else begin
            acc    <= mul_acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          if (cnt == '0) state <= S_FIX;
`ifdef MDU_EARLY_OUT_EN
          // Nothing left to add once the unconsumed multiplier bits are zero
          if (!is_div_q && (mplier[WIDTH-1:1] == '0)) state <= S_FIX;
`endif
        end

        S_FIX: begin
          state  <= S_IDLE;
          done_q <= 1'b1;
          if (is_div_q) begin
            if (dz_q) begin
              hi_q   <= a_q;
              lo_q   <= '1;
              div0_q <= 1'b1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = done_q;
  assign bus.div0  = div0_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.state = state;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (WIDTH=32). Expected HI/LO/div0
// come from a 64-bit arithmetic reference model; expected latency from the
// bit length of the multiplier when MDU_EARLY_OUT_EN is defined.
module tb_mdu_iterative;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_q[$];

  mdu_iterative_if #(.WIDTH(W)) bus();

  mdu_iterative #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Count every done pulse, sampled mid-cycle
  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands
  function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] e_hi,
                                    output logic [W-1:0] e_lo, output logic e_dz);
    longint sa, sb, sq, sr;
    logic [63:0] p, ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    e_dz = 1'b0;
    p = 64'h0;
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = ua * ub;
      2'b10: begin
        if (b == 32'h0) begin
          e_dz = 1'b1;
          p = {a, 32'hFFFF_FFFF};
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          p = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) begin
          e_dz = 1'b1;
          p = {a, 32'hFFFF_FFFF};
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          p = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    e_hi = p[63:32];
    e_lo = p[31:0];
  endfunction

  // Edges from accept to done
  function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic [W-1:0] mag;
    int n;
`endif
    if (op[1] && b == 32'h0) return 1;
`ifdef MDU_EARLY_OUT_EN
    if (!op[1]) begin
      mag = (op == 2'b00 && b[W-1]) ? -b : b;
      n = 0;
      while (mag != 32'h0) begin
        n++;
        mag = mag >> 1;
      end
      if (n < 1) n = 1;
      return n + 1;
    end
`endif
    return W + 1;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hi",    64'(bus.hi), 64'h0);
    check_eq("rst_lo",    64'(bus.lo), 64'h0);
    check_eq("rst_busy",  64'(bus.busy), 64'h0);
    check_eq("rst_done",  64'(bus.done), 64'h0);
    check_eq("rst_div0",  64'(bus.div0), 64'h0);
    check_eq("rst_state", 64'(bus.state), 64'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Driver: launch one op, follow it to done and score it.
  // disturb: mid-op MTHI write plus a stray start. wr_lo: MTLO on the accepting edge.
  task automatic run_op(input logic [1:0] op_i, input logic [W-1:0] a_i,
                        input logic [W-1:0] b_i, input bit disturb, input bit wr_lo);
    logic [W-1:0] e_hi, e_lo, g_hi, g_lo;
    logic e_dz;
    int lat, bcnt, exp_lat, d0;
    ref_model(op_i, a_i, b_i, e_hi, e_lo, e_dz);
    exp_q.push_back(e_hi);
    exp_q.push_back(e_lo);
    exp_lat = ref_latency(op_i, b_i);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    if (wr_lo) begin
      bus.lo_we = 1'b1;
      bus.wdata = 32'h0BAD_F00D;
    end
    d0 = done_cnt;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    check_eq("busy_rise", 64'(bus.busy), 64'h1);
    check_eq("div0_clr",  64'(bus.div0), 64'h0);
    if (wr_lo) check_eq("lo_wr_with_start", 64'(bus.lo), 64'h0BAD_F00D);
    lat  = 0;
    bcnt = 1;
    while (!bus.done && lat < 100) begin
      if (disturb && lat == 4) begin
        bus.hi_we = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        bus.start = 1'b1;
      end else begin
        bus.hi_we = 1'b0;
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) bcnt++;
    end
    bus.hi_we = 1'b0;
    bus.start = 1'b0;
    check_eq("latency",     64'(lat), 64'(exp_lat));
    check_eq("busy_cycles", 64'(bcnt), 64'(exp_lat));
    check_eq("busy_fall",   64'(bus.busy), 64'h0);
    g_hi = exp_q.pop_front();
    g_lo = exp_q.pop_front();
    check_eq("hi",   64'(bus.hi), 64'(g_hi));
    check_eq("lo",   64'(bus.lo), 64'(g_lo));
    check_eq("div0", 64'(bus.div0), 64'(e_dz));
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", 64'(bus.done), 64'h0);
    check_eq("done_count",     64'(done_cnt - d0), 64'h1);
    check_eq("idle_after",     64'(bus.busy), 64'h0);
  endtask

  task automatic idle_write(input bit to_hi, input logic [W-1:0] v);
    @(negedge clk);
    if (to_hi) bus.hi_we = 1'b1;
    else       bus.lo_we = 1'b1;
    bus.wdata = v;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    if (to_hi) check_eq("mthi_idle", 64'(bus.hi), 64'(v));
    else       check_eq("mtlo_idle", 64'(bus.lo), 64'(v));
  endtask

  initial begin
    logic [1:0] r_op;
    logic [W-1:0] r_a, r_b;
    int sel, d0;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    apply_reset();

    // Directed cases
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("multu_max_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    check_eq("multu_max_lo", 64'(bus.lo), 64'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    check_eq("mult_neg_lo", 64'(bus.lo), 64'hFFFF_FFEB);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check_eq("div_neg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    run_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
    run_op(2'b11, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("div0_hold", 64'(bus.div0), 64'h1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
    run_op(2'b10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    // MTHI/MTLO in idle, while busy, and with the accepting start
    idle_write(1'b1, 32'hA5A5_A5A5);
    idle_write(1'b0, 32'h5A5A_5A5A);
    run_op(2'b01, 32'h0001_0000, 32'h0003_0000, 1'b1, 1'b0);
    run_op(2'b11, 32'd100, 32'd9, 1'b1, 1'b1);
    run_op(2'b01, 32'd5, 32'd1, 1'b0, 1'b0);
    run_op(2'b00, 32'd5, 32'd0, 1'b0, 1'b0);

    // Reset in the middle of a multiply
    idle_write(1'b1, 32'h1234_5678);
    idle_write(1'b0, 32'h8765_4321);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'h0000_0123;
    bus.b     = 32'hFFFF_0001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    d0 = done_cnt;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("abort_busy", 64'(bus.busy), 64'h0);
    check_eq("abort_hi",   64'(bus.hi), 64'h0);
    check_eq("abort_lo",   64'(bus.lo), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("abort_no_done", 64'(done_cnt - d0), 64'h0);
    check_eq("abort_idle",    64'(bus.busy), 64'h0);

    // Randomized operations, biased toward boundary operands
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      sel  = $urandom_range(0, 7);
      case (sel)
        0:       r_b = 32'h0;
        1:       r_b = 32'h1;
        2:       r_b = 32'hFFFF_FFFF;
        3:       r_b = 32'($urandom_range(0, 15));
        4:       r_b = 32'h8000_0000;
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    check_eq("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
